// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR access arbiter: requester indices,
// arbiter state encoding and the 10-bit burst length type.
package ddr_arb_pkg;

  localparam int NUM_REQ = 4;

  localparam logic [1:0] REQ_INSTR = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_JMP   = 2'd2;
  localparam logic [1:0] REQ_STORE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef logic [9:0] burst_len_t;

endpackage

// File: rtl/ddr_access_arbiter_rr.sv
// Combinational 4-way round-robin picker: the first set request searching
// upward from ptr+1 (mod 4) wins.
module rr_arbiter_4
  import ddr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [1:0]         winner_idx,
  output logic               any_req
);

  logic       found_s;
  logic [1:0] cand_s;

  // Scan the four positions after the pointer; the pointer itself is checked last.
  always_comb begin
    winner_onehot = {NUM_REQ{1'b0}};
    winner_idx    = ptr;
    found_s       = 1'b0;
    cand_s        = ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = ptr + 2'(i);
      if (!found_s && req[cand_s]) begin
        found_s               = 1'b1;
        winner_idx            = cand_s;
        winner_onehot[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ddr_access_arbiter.sv
// Shares the single DDR burst port between the instruction-cache read path and
// the data cache's read, jump-address read and store requesters; one burst at a time.
module ddr_access_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int DDR_ADDR_WIDTH    = 28,
  parameter int DATA_CACHE_DEPTH  = 16,
  parameter int INSTR_CACHE_DEPTH = 16,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [DDR_ADDR_WIDTH-1:0] rd_addr_instr,
  input  logic [DDR_ADDR_WIDTH-1:0] rd_addr_data,
  input  logic [DDR_ADDR_WIDTH-1:0] rd_addr_jmp,
  input  logic [DDR_ADDR_WIDTH-1:0] wr_addr_data,
  input  logic [DATA_WIDTH-1:0]     wr_data_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        rd_data_valid,
  output logic                      wr_data_req_out,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [9:0]                rd_burst_len,
  input  logic                      rd_burst_data_valid,
  input  logic                      rd_burst_finish,
  output logic                      wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [9:0]                wr_burst_len,
  output logic [DATA_WIDTH-1:0]     wr_burst_data,
  input  logic                      wr_burst_data_req,
  input  logic                      wr_burst_finish,
  output logic                      arb_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam burst_len_t       LEN_INSTR = burst_len_t'(INSTR_CACHE_DEPTH);
  localparam burst_len_t       LEN_DATA  = burst_len_t'(DATA_CACHE_DEPTH);
  localparam burst_len_t       LEN_JMP   = 10'd1;

  arb_state_e                state_r, state_s;
  logic [1:0]                ptr_r, ptr_s;
  logic [CNT_W-1:0]          cnt_r, cnt_s;
  logic [NUM_REQ-1:0]        grant_s, done_s;
  logic                      rd_req_s, wr_req_s, timeout_s;
  logic [DDR_ADDR_WIDTH-1:0] rd_addr_s, wr_addr_s, rd_addr_mux_s;
  burst_len_t                rd_len_s, wr_len_s, rd_len_mux_s;
  logic [NUM_REQ-1:0]        win_onehot_s;
  logic [1:0]                win_idx_s;
  logic                      any_req_s, finish_s, busy_s;

  rr_arbiter_4 u_rr (
    .req           (req),
    .ptr           (ptr_r),
    .winner_onehot (win_onehot_s),
    .winner_idx    (win_idx_s),
    .any_req       (any_req_s)
  );

  // Read address/length for whichever reader wins this arbitration round.
  always_comb begin
    rd_addr_mux_s = rd_addr_instr;
    rd_len_mux_s  = LEN_INSTR;
    case (win_idx_s)
      REQ_INSTR: begin rd_addr_mux_s = rd_addr_instr; rd_len_mux_s = LEN_INSTR; end
      REQ_DATA:  begin rd_addr_mux_s = rd_addr_data;  rd_len_mux_s = LEN_DATA;  end
      REQ_JMP:   begin rd_addr_mux_s = rd_addr_jmp;   rd_len_mux_s = LEN_JMP;   end
      default:   begin rd_addr_mux_s = rd_addr_instr; rd_len_mux_s = LEN_INSTR; end
    endcase
  end

  // Only the finish pulse of the direction actually in flight ends the burst.
  assign finish_s = grant[REQ_STORE] ? wr_burst_finish : rd_burst_finish;

  // Next-state and next-output logic for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    grant_s   = grant;
    done_s    = {NUM_REQ{1'b0}};
    rd_req_s  = rd_burst_req;
    wr_req_s  = wr_burst_req;
    rd_addr_s = rd_burst_addr;
    wr_addr_s = wr_burst_addr;
    rd_len_s  = rd_burst_len;
    wr_len_s  = wr_burst_len;
    timeout_s = arb_timeout;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_BUSY;
          grant_s = win_onehot_s;
          ptr_s   = win_idx_s;
          cnt_s   = {CNT_W{1'b0}};
          if (win_idx_s == REQ_STORE) begin
            wr_req_s  = 1'b1;
            wr_addr_s = wr_addr_data;
            wr_len_s  = LEN_DATA;
          end else begin
            rd_req_s  = 1'b1;
            rd_addr_s = rd_addr_mux_s;
            rd_len_s  = rd_len_mux_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (finish_s || (cnt_r == CNT_LAST)) begin
          state_s  = ST_DONE;
          done_s   = grant;
          rd_req_s = 1'b0;
          wr_req_s = 1'b0;
          cnt_s    = {CNT_W{1'b0}};
          // A finish arriving on the last allowed cycle still counts as normal completion.
          if (!finish_s) begin
            timeout_s = 1'b1;
          end else begin
            timeout_s = arb_timeout;
          end
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        grant_s = {NUM_REQ{1'b0}};
      end
      default: begin
        state_s  = ST_IDLE;
        grant_s  = {NUM_REQ{1'b0}};
        rd_req_s = 1'b0;
        wr_req_s = 1'b0;
        cnt_s    = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ptr_r         <= REQ_STORE;
      cnt_r         <= {CNT_W{1'b0}};
      grant         <= {NUM_REQ{1'b0}};
      done          <= {NUM_REQ{1'b0}};
      rd_burst_req  <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_addr <= {DDR_ADDR_WIDTH{1'b0}};
      wr_burst_addr <= {DDR_ADDR_WIDTH{1'b0}};
      rd_burst_len  <= 10'd0;
      wr_burst_len  <= 10'd0;
      arb_timeout   <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      cnt_r         <= cnt_s;
      grant         <= grant_s;
      done          <= done_s;
      rd_burst_req  <= rd_req_s;
      wr_burst_req  <= wr_req_s;
      rd_burst_addr <= rd_addr_s;
      wr_burst_addr <= wr_addr_s;
      rd_burst_len  <= rd_len_s;
      wr_burst_len  <= wr_len_s;
      arb_timeout   <= timeout_s;
    end
  end

  // Strobes reach the owner only while its burst is actually in flight.
  assign busy_s          = (state_r == ST_BUSY);
  assign rd_data_valid   = busy_s ? ({NUM_REQ{rd_burst_data_valid}} & grant & 4'b0111) : 4'b0000;
  assign wr_data_req_out = busy_s & wr_burst_data_req & grant[REQ_STORE];
  assign wr_burst_data   = grant[REQ_STORE] ? wr_data_in : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_ddr_access_arbiter.sv
// Self-checking bench for ddr_access_arbiter: directed vector table, corner
// sequences and randomized bursts checked against a transaction-level model.
module tb_ddr_access_arbiter;

  localparam int DW = 16;
  localparam int AW = 28;
  localparam int T  = 32;
  localparam int M_RAND = 0, M_FULL = 1, M_DROP = 2, M_SIMUL = 3, M_TO = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [AW-1:0] rd_addr_instr = '0, rd_addr_data = '0, rd_addr_jmp = '0, wr_addr_data = '0;
  logic [DW-1:0] wr_data_in = '0;
  logic [3:0] grant, done, rd_data_valid;
  logic wr_data_req_out, rd_burst_req, wr_burst_req, arb_timeout;
  logic [AW-1:0] rd_burst_addr, wr_burst_addr;
  logic [9:0] rd_burst_len, wr_burst_len;
  logic [DW-1:0] wr_burst_data;
  logic rd_burst_data_valid = 1'b0, rd_burst_finish = 1'b0;
  logic wr_burst_data_req = 1'b0, wr_burst_finish = 1'b0;

  int checks = 0;
  int errors = 0;
  int ptr_m = 3;
  logic exp_to = 1'b0;

  ddr_access_arbiter #(
    .DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .DATA_CACHE_DEPTH(16),
    .INSTR_CACHE_DEPTH(16), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .rd_addr_instr(rd_addr_instr), .rd_addr_data(rd_addr_data),
    .rd_addr_jmp(rd_addr_jmp), .wr_addr_data(wr_addr_data), .wr_data_in(wr_data_in),
    .grant(grant), .done(done), .rd_data_valid(rd_data_valid),
    .wr_data_req_out(wr_data_req_out), .rd_burst_req(rd_burst_req),
    .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
    .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr),
    .wr_burst_len(wr_burst_len), .wr_burst_data(wr_burst_data),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int         dly;
    int         mode;
    logic [3:0] exp_grant;
    logic [9:0] exp_len;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requester found scanning upward from last winner + 1.
  function automatic int model_pick(input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [9:0] model_len(input int w);
    return (w == 2) ? 10'd1 : 10'd16;
  endfunction

  task automatic check_all_zero(input string name);
    chk({name, "_grant"}, 64'(grant), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_reqs"}, 64'({rd_burst_req, wr_burst_req}), 64'd0);
    chk({name, "_addrs"}, 64'({rd_burst_addr, wr_burst_addr}), 64'd0);
    chk({name, "_lens"}, 64'({rd_burst_len, wr_burst_len}), 64'd0);
    chk({name, "_timeout"}, 64'(arb_timeout), 64'd0);
  endtask

  // One complete burst starting from IDLE; returns in IDLE with req released.
  task automatic do_burst(input logic [3:0] r, input int dly, input int mode,
                          input logic [3:0] exp_g, input logic [9:0] exp_l);
    int w, busy_n;
    logic [31:0] tmp;
    logic [AW-1:0] exp_a;
    logic rv, wq;
    logic [DW-1:0] wd;
    w = 0;
    for (int i = 0; i < 4; i++) if (exp_g[i]) w = i;
    tmp = $urandom; rd_addr_instr = (r == 4'b0001) ? 28'h100 : tmp[AW-1:0];
    tmp = $urandom; rd_addr_data  = tmp[AW-1:0];
    tmp = $urandom; rd_addr_jmp   = tmp[AW-1:0];
    tmp = $urandom; wr_addr_data  = tmp[AW-1:0];
    exp_a = (w == 0) ? rd_addr_instr : (w == 1) ? rd_addr_data : (w == 2) ? rd_addr_jmp : wr_addr_data;
    req = r;
    tick();
    ptr_m = w;
    chk("grant", 64'(grant), 64'(exp_g));
    chk("burst_req_dir", 64'({rd_burst_req, wr_burst_req}), (w == 3) ? 64'b01 : 64'b10);
    chk("burst_addr", 64'((w == 3) ? wr_burst_addr : rd_burst_addr), 64'(exp_a));
    chk("burst_len", 64'((w == 3) ? wr_burst_len : rd_burst_len), 64'(exp_l));
    chk("done_busy", 64'(done), 64'd0);
    if (mode == M_DROP) req = 4'b0000;
    busy_n = (mode == M_TO || mode == M_SIMUL) ? T : dly + 1;
    for (int c = 0; c < busy_n; c++) begin
      rv = (mode == M_FULL) ? 1'b1 : 1'($urandom_range(0, 1));
      wq = (mode == M_FULL) ? 1'b1 : 1'($urandom_range(0, 1));
      tmp = $urandom; wd = tmp[DW-1:0];
      rd_burst_data_valid = rv;
      wr_burst_data_req   = wq;
      wr_data_in          = wd;
      rd_burst_finish = (w == 3) ? 1'($urandom_range(0, 1)) : (mode != M_TO && c == busy_n - 1);
      wr_burst_finish = (w != 3) ? 1'($urandom_range(0, 1)) : (mode != M_TO && c == busy_n - 1);
      #1;
      chk("rd_data_valid", 64'(rd_data_valid), (rv && w < 3) ? 64'(exp_g) : 64'd0);
      chk("wr_data_req_out", 64'(wr_data_req_out), 64'(wq && w == 3));
      chk("wr_burst_data", 64'(wr_burst_data), (w == 3) ? 64'(wd) : 64'd0);
      chk("burst_req_held", 64'(rd_burst_req | wr_burst_req), 64'd1);
      chk("done_quiet", 64'(done), 64'd0);
      tick();
    end
    rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
    if (mode == M_TO) exp_to = 1'b1;
    chk("done_pulse", 64'(done), 64'(exp_g));
    chk("grant_in_done", 64'(grant), 64'(exp_g));
    chk("burst_req_off", 64'({rd_burst_req, wr_burst_req}), 64'd0);
    chk("arb_timeout", 64'(arb_timeout), 64'(exp_to));
    rd_burst_data_valid = 1'b1; wr_burst_data_req = 1'b1;
    #1;
    chk("strobe_in_done", 64'({rd_data_valid, wr_data_req_out}), 64'd0);
    tick();
    req = 4'b0000;
    rd_burst_data_valid = 1'b0; wr_burst_data_req = 1'b0;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("grant_cleared", 64'(grant), 64'd0);
  endtask

  initial begin
    int w, dly, mode;
    logic [3:0] r;
    tbl[0] = '{4'b0001, 3,  M_RAND,  4'b0001, 10'd16};
    tbl[1] = '{4'b1111, 15, M_FULL,  4'b0010, 10'd16};
    tbl[2] = '{4'b1111, 0,  M_RAND,  4'b0100, 10'd1};
    tbl[3] = '{4'b1111, 15, M_FULL,  4'b1000, 10'd16};
    tbl[4] = '{4'b1111, 2,  M_RAND,  4'b0001, 10'd16};
    tbl[5] = '{4'b1010, 1,  M_DROP,  4'b0010, 10'd16};
    tbl[6] = '{4'b1010, 4,  M_RAND,  4'b1000, 10'd16};
    tbl[7] = '{4'b0101, 0,  M_RAND,  4'b0001, 10'd16};
    tbl[8] = '{4'b1100, 0,  M_SIMUL, 4'b0100, 10'd1};
    tbl[9] = '{4'b1001, 0,  M_RAND,  4'b1000, 10'd16};

    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    ptr_m = 3;

    for (int i = 0; i < 10; i++) begin
      do_burst(tbl[i].req, tbl[i].dly, tbl[i].mode, tbl[i].exp_grant, tbl[i].exp_len);
    end

    // Strobes and finish pulses in IDLE must not start or end anything.
    rd_burst_data_valid = 1'b1; wr_burst_data_req = 1'b1;
    rd_burst_finish = 1'b1; wr_burst_finish = 1'b1;
    #1;
    chk("idle_strobes", 64'({rd_data_valid, wr_data_req_out}), 64'd0);
    tick();
    chk("idle_noise_state", 64'({grant, done, rd_burst_req, wr_burst_req}), 64'd0);
    rd_burst_data_valid = 1'b0; wr_burst_data_req = 1'b0;
    rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;

    for (int n = 0; n < 40; n++) begin
      r = 4'($urandom_range(1, 15));
      w = model_pick(r);
      dly = $urandom_range(0, T - 2);
      mode = $urandom_range(0, 2);
      do_burst(r, dly, mode, 4'(1 << w), model_len(w));
    end

    r = 4'b0100;
    w = model_pick(r);
    do_burst(r, 0, M_TO, 4'(1 << w), model_len(w));
    r = 4'b0011;
    w = model_pick(r);
    do_burst(r, 2, M_RAND, 4'(1 << w), model_len(w));

    // Reset in the middle of a burst: everything returns to reset values, no done.
    req = 4'b0001;
    tick();
    chk("pre_reset_busy", 64'(rd_burst_req), 64'd1);
    rst = 1'b1;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b0;
    req = 4'b0000;
    ptr_m = 3;
    exp_to = 1'b0;
    tick();
    chk("no_done_after_reset", 64'(done), 64'd0);
    do_burst(4'b0001, 1, M_RAND, 4'b0001, 10'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
